// File: rtl/voice_scan_mixer_if.sv
// Handshake bundle between the mixer, its voice mux and the sample-rate divider.
interface voice_scan_mixer_if;
  logic       sample_tick;
  logic [7:0] voice_en;
  logic [7:0] mux_in;
  logic [2:0] sel;
  logic [7:0] sample;
  logic       sample_valid;
  logic       busy;
  logic       overrun;

  modport master (
    output sample_tick, voice_en, mux_in,
    input  sel, sample, sample_valid, busy, overrun
  );

  modport slave (
    input  sample_tick, voice_en, mux_in,
    output sel, sample, sample_valid, busy, overrun
  );
endinterface

// File: rtl/voice_scan_mixer.sv
// Steps the voice mux select 0..7 once per sample tick, sums enabled voices,
// then emits one shifted, saturated 8-bit mixed sample with a valid strobe.
module voice_scan_mixer #(
  parameter int GAIN_SHIFT = 3
) (
  input logic              clk,
  input logic              reset,
  voice_scan_mixer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state;
  logic [2:0]  sel;
  logic [7:0]  en_q;
  logic [10:0] acc;
  logic [7:0]  sample;
  logic        sample_valid;
  logic        busy;
  logic        overrun;
  logic [10:0] shifted;
  logic [7:0]  sat;

  // Saturation happens after the shift, so a full-scale sum at shift 0 clamps.
  assign shifted = acc >> GAIN_SHIFT;
  assign sat     = (shifted > 11'd255) ? 8'hFF : shifted[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      sel          <= 3'd0;
      en_q         <= 8'h00;
      acc          <= 11'd0;
      sample       <= 8'd0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (bus.sample_tick && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          sel <= 3'd0;
          if (bus.sample_tick) begin
            en_q  <= bus.voice_en;
            acc   <= 11'd0;
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          // sel doubles as the voice counter; it wraps to 0 after voice 7.
          acc <= acc + (en_q[sel] ? {3'b000, bus.mux_in} : 11'd0);
          sel <= sel + 3'd1;
          if (sel == 3'd7) state <= DONE;
        end
        DONE: begin
          sample       <= sat;
          sample_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel          = sel;
  assign bus.sample       = sample;
  assign bus.sample_valid = sample_valid;
  assign bus.busy         = busy;
  assign bus.overrun      = overrun;
endmodule

// File: doc/voice_scan_mixer.md
# voice_scan_mixer

- Upstream sequencer for the 8-input, 8-bit voice select multiplexer.
- Once per audio sample period it steps the mux select through all eight voices, one per clock.
- Each cycle it accumulates the selected 8-bit voice sample, then emits one scaled, saturated 8-bit mixed sample with a one-cycle valid strobe.
- Sits between the per-voice oscillators (via the mux) and the output DAC/PWM stage.

## Interface
- GAIN_SHIFT, 3, right-shift applied to the 11-bit voice sum; legal range 0..3; result saturates to 8'd255.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- sample_tick  input  1  one-cycle pulse from the sample-rate divider requesting a new mixed sample.
- voice_en  input  8  per-voice enable; bit k gates voice k; captured when a tick is accepted.
- mux_in  input  8  sample returned by the multiplexer for the current sel (combinational path, same cycle).
- sel  output  3  select driven to the multiplexer; registered.
- sample  output  8  most recent mixed sample; registered and held between updates.
- sample_valid  output  1  one-cycle pulse when sample updates.
- busy  output  1  high while a scan is in progress (states SCAN and DONE).
- overrun  output  1  sticky flag: a sample_tick arrived while busy; cleared only by reset.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - sel = 0.
  - On sample_tick:
    - capture voice_en into en_q;
    - clear the 11-bit accumulator;
    - cnt = 0; go to SCAN.
- SCAN:
  - sel = cnt.
  - Each edge: acc += (en_q[cnt] ? mux_in : 0); cnt += 1.
  - After the edge that adds voice 7: go to DONE, sel = 0.
- DONE:
  - One edge: sample <= min(acc >> GAIN_SHIFT, 255); sample_valid <= 1; go to IDLE.
- Arithmetic:
  - Unsigned throughout.
  - acc is 11 bits, maximum 8 × 255 = 2040, so it never wraps.
  - The shift truncates (no rounding).
  - Saturation is applied after the shift.
- sample_tick while busy:
  - The tick is ignored; the current scan is unaffected.
  - overrun <= 1.
- voice_en changes mid-scan have no effect until the next accepted tick.
- Reset, including mid-scan:
  - State = IDLE, sel = 0, sample = 0, sample_valid = 0, busy = 0, overrun = 0, acc = 0.
  - No partial sample is emitted.

## Timing
- Tick sampled high in IDLE at edge E0:
  - cycles E0..E8: busy = 1;
  - E(1+k): accumulates voice k (k = 0..7), with sel = k during the cycle before that edge;
  - E9: sample and sample_valid update; busy falls.
- Latency: tick-accepting edge to sample_valid assertion = 9 clocks.
- sample_valid is high for exactly one cycle.
- Minimum accepted tick spacing is 10 clocks.
  - A tick coincident with E1..E9 sets overrun.
  - A tick at E10 starts a new scan.
- sel changes only on clock edges; mux_in must settle within one cycle (combinational mux).
- Reset wins over sample_tick at the same edge.

## Test plan
- All voices 8'd100, voice_en = 8'hFF, GAIN_SHIFT = 3, single tick:
  - sel walks 0..7 on consecutive cycles;
  - sample = 100 with sample_valid 9 clocks after the tick;
  - busy high for 9 cycles.
- Voices 10, 20, …, 80 (sum 360), voice_en = 8'hFF:
  - GAIN_SHIFT = 3 → sample = 45;
  - GAIN_SHIFT = 2 → sample = 90;
  - voice_en = 8'h0F with GAIN_SHIFT = 3 → sum 100 → sample = 12 (truncation).
- Saturation, all voices 8'd255, voice_en = 8'hFF:
  - GAIN_SHIFT = 0 → sample = 255 (not 2040 wrapped);
  - GAIN_SHIFT = 3 → sample = 255.
- Overrun: ticks at E0 and E4:
  - exactly one sample_valid, at E9;
  - overrun = 1 from E4 onward and stays set;
  - voice_en toggled at E3 does not change the result.
- Back-to-back ticks at E0 and E10: two sample_valid pulses (E9, E19); overrun stays 0.
- Reset asserted at E5 of a scan:
  - next cycle: sel = 0, busy = 0, sample = 0, overrun = 0;
  - no sample_valid;
  - a subsequent tick produces a correct full sample.
